// File: rtl/spi_slave.sv
// Byte-wide SPI slave: oversamples sclk/ss/mosi on clk, supports all CPOL/CPHA modes, MSB first.
// Received bytes appear on mosi_dataout with rx_valid; tx_buf is shifted out on miso.
//
// state | meaning
// IDLE  | waiting for ss to fall
// LOAD  | latch mode, load tx_shift from tx_buf
// SHIFT | sampling mosi / shifting miso on detected sclk edges
// DONE  | byte complete, reload tx_shift for a possible next byte
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] datain,
  input  logic              write,
  output logic              miso,
  output logic [DATA_W-1:0] mosi_dataout,
  output logic              rx_valid,
  output logic              busy,
  output logic [2:0]        stateout
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b011
  } state_t;

  state_t state, state_nxt;

  logic sclk_m, sclk_s, sclk_d;
  logic ss_m, ss_s, ss_d;
  logic mosi_m, mosi_s;
  logic cpol_l, cpha_l;

  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, last_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      ss_m   <= 1'b0;
      ss_s   <= 1'b0;
      ss_d   <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ss_m   <= ss;
      ss_s   <= ss_m;
      ss_d   <= ss_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  // Edges are defined relative to the idle level, so one decode serves all four modes.
  assign lead_edge   = (sclk_d == cpol_l) && (sclk_s != cpol_l);
  assign trail_edge  = (sclk_d != cpol_l) && (sclk_s == cpol_l);
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge  : trail_edge;
  assign ss_fall     = ss_d && !ss_s;
  assign last_bit    = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT: begin
        if (ss_s)                          state_nxt = IDLE;
        else if (sample_edge && last_bit)  state_nxt = DONE;
      end
      DONE:    state_nxt = ss_s ? IDLE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_l       <= 1'b0;
      cpha_l       <= 1'b0;
      tx_buf       <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      mosi_dataout <= '0;
    end else begin
      if (write) tx_buf <= datain;
      case (state)
        LOAD: begin
          cpol_l   <= cpol;
          cpha_l   <= cpha;
          tx_shift <= tx_buf;
          bit_cnt  <= '0;
        end
        SHIFT: begin
          if (!ss_s) begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
              bit_cnt  <= bit_cnt + CNT_W'(1);
              // Publish the completed byte so it is valid during the DONE strobe.
              if (last_bit) mosi_dataout <= {rx_shift[DATA_W-2:0], mosi_s};
            end else if (shift_edge && (bit_cnt != '0)) begin
              tx_shift <= tx_shift << 1;
            end
          end
        end
        DONE: begin
          tx_shift <= tx_buf;
          bit_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign miso     = ss_s ? 1'b0 : tx_shift[DATA_W-1];
  assign rx_valid = (state == DONE);
  assign busy     = (state != IDLE);
  assign stateout = state;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-level SPI master model, queued expectations,
// and independent monitors for rx_valid/mosi_dataout and master-received miso bytes.
module tb_spi_slave;

  localparam int DATA_W = 8;
  localparam int HP     = 4;

  logic              clk = 1'b0;
  logic              reset, sclk, ss, mosi, cpol, cpha, write;
  logic [DATA_W-1:0] datain;
  logic              miso, rx_valid, busy;
  logic [DATA_W-1:0] mosi_dataout;
  logic [2:0]        stateout;

  spi_slave #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .cpol(cpol), .cpha(cpha), .datain(datain), .write(write),
    .miso(miso), .mosi_dataout(mosi_dataout), .rx_valid(rx_valid),
    .busy(busy), .stateout(stateout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] got_tx_q[$];
  logic [2:0] st_q[$];
  logic [7:0] q_bytes[$];
  logic [7:0] q_wval[$];
  logic       q_wen[$];
  logic [7:0] model_buf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // rx_valid monitor: pulse width, data against queue, plus a record of state changes.
  initial begin
    int rv_len;
    logic [2:0] last_st;
    rv_len  = 0;
    last_st = 3'd0;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (rv_len == 0) begin
          if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got rx_valid with %0h, expected none", mosi_dataout);
          end else begin
            check("rx_data", {24'd0, mosi_dataout}, {24'd0, exp_rx_q.pop_front()});
          end
        end
        rv_len++;
      end else if (rv_len != 0) begin
        check("rx_valid_len", rv_len, 1);
        rv_len = 0;
      end
      if (stateout !== last_st) begin
        st_q.push_back(stateout);
        last_st = stateout;
      end
    end
  end

  // miso monitor: compares bytes the master collected against the tx_buf model.
  initial begin
    logic [7:0] g;
    forever begin
      @(negedge clk);
      while (got_tx_q.size() > 0) begin
        g = got_tx_q.pop_front();
        if (exp_tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL miso_unexpected: got %0h, expected no byte", g);
        end else begin
          check("miso_byte", {24'd0, g}, {24'd0, exp_tx_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic do_wr,
                          input logic [7:0] wr_val, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (do_wr && i == 3) begin
        datain = wr_val;
        write  = 1'b1;
        @(negedge clk);
        write  = 1'b0;
      end
      if (!cpha) begin
        mosi = tx[i];
        wait_clk(HP);
        rx[i] = miso;
        sclk  = ~cpol;
        wait_clk(HP);
        sclk  = cpol;
      end else begin
        wait_clk(HP);
        sclk = ~cpol;
        mosi = tx[i];
        wait_clk(HP);
        rx[i] = miso;
        sclk  = cpol;
      end
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input logic wen, input logic [7:0] wv);
    q_bytes.push_back(b);
    q_wen.push_back(wen);
    q_wval.push_back(wv);
  endtask

  task automatic wr_idle(input logic [7:0] v);
    datain = v;
    write  = 1'b1;
    @(negedge clk);
    write  = 1'b0;
    model_buf = v;
  endtask

  task automatic run_burst(input logic m_cpol, input logic m_cpha);
    logic [7:0] r;
    cpol = m_cpol;
    cpha = m_cpha;
    sclk = m_cpol;
    wait_clk(2);
    ss = 1'b0;
    wait_clk(4);
    for (int k = 0; k < q_bytes.size(); k++) begin
      exp_rx_q.push_back(q_bytes[k]);
      exp_tx_q.push_back(model_buf);
      spi_bits(q_bytes[k], 8, q_wen[k], q_wval[k], r);
      if (q_wen[k]) model_buf = q_wval[k];
      got_tx_q.push_back(r);
    end
    wait_clk(4);
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clk(6);
    q_bytes.delete();
    q_wen.delete();
    q_wval.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     {31'd0, miso},         0);
    check({tag, "_rxdata"},   {24'd0, mosi_dataout}, 0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid},     0);
    check({tag, "_busy"},     {31'd0, busy},         0);
    check({tag, "_state"},    {29'd0, stateout},     0);
  endtask

  initial begin
    logic [7:0]  r;
    logic [14:0] seq;
    logic [1:0]  mm;
    int          sent, nb;

    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; write = 1'b0; datain = '0;
    model_buf = 8'h00;
    wait_clk(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_clk(4);

    // Mode 0: ss stays low through DONE, so the slave re-enters SHIFT before ss rises.
    wr_idle(8'hA5);
    st_q.delete();
    add_byte(8'hE5, 1'b0, 8'h00);
    run_burst(1'b0, 1'b0);
    check("m0_state_count", st_q.size(), 5);
    if (st_q.size() == 5) begin
      seq = '0;
      for (int i = 0; i < 5; i++) seq = {seq[11:0], st_q[i]};
      check("m0_state_seq", {17'd0, seq}, {17'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd0});
    end
    check("m0_rx_count", exp_rx_q.size(), 0);

    wr_idle(8'h3C);
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      add_byte(8'h81, 1'b0, 8'h00);
      run_burst(mm[1], mm[0]);
      check("mode_rx_count", exp_rx_q.size(), 0);
    end

    wr_idle(8'h96);
    add_byte(8'h12, 1'b1, 8'hC3);
    add_byte(8'h34, 1'b0, 8'h00);
    run_burst(1'b0, 1'b0);
    check("burst_rx_count", exp_rx_q.size(), 0);

    // Abort after four bits of 0xF0.
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    ss = 1'b0;
    wait_clk(4);
    spi_bits(8'hF0, 4, 1'b0, 8'h00, r);
    wait_clk(4);
    ss = 1'b1;
    wait_clk(4);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_miso", {31'd0, miso}, 0);
    check("abort_rxdata", {24'd0, mosi_dataout}, 32'h34);
    add_byte(8'h5A, 1'b0, 8'h00);
    run_burst(1'b0, 1'b0);
    check("after_abort_rx_count", exp_rx_q.size(), 0);

    // Reset in the middle of a byte.
    ss = 1'b0;
    wait_clk(4);
    spi_bits(8'hE5, 3, 1'b0, 8'h00, r);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    reset = 1'b0;
    model_buf = 8'h00;
    wait_clk(4);
    add_byte(8'hE5, 1'b0, 8'h00);
    run_burst(1'b0, 1'b0);
    check("after_reset_rx_count", exp_rx_q.size(), 0);

    // Randomized bursts at the minimum half-period.
    sent = 0;
    while (sent < 100) begin
      nb = $urandom_range(1, 3);
      if (nb > 100 - sent) nb = 100 - sent;
      if ($urandom_range(0, 1) == 1) wr_idle(8'($urandom));
      for (int k = 0; k < nb; k++)
        add_byte(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      mm = 2'($urandom_range(0, 3));
      run_burst(mm[1], mm[0]);
      sent += nb;
    end

    wait_clk(10);
    check("rx_leftover", exp_rx_q.size(), 0);
    check("tx_leftover", exp_tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
